// File: rtl/cpu_controller.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | cpu_controller: fixed 8-phase sequencing controller for the 8-bit RISC CPU.  |
// | Optional single-step mode (step_i/stalled_o) enabled by CPU_CTRL_STEP_EN.    |
// | Rev 1.0                                                                      |
// +-----------------------------------------------------------------------------+
module cpu_controller #(
  parameter int OPCODE_W = 3,
  parameter int PHASE_W  = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] opcode_i,
  input  logic                zero_i,
`ifdef CPU_CTRL_STEP_EN
  input  logic                step_i,
  output logic                stalled_o,
`endif
  output logic [PHASE_W-1:0]  phase_o,
  output logic                sel_o,
  output logic                rd_o,
  output logic                ld_ir_o,
  output logic                inc_pc_o,
  output logic                ld_pc_o,
  output logic                ld_ac_o,
  output logic                wr_o,
  output logic                data_e_o,
  output logic                halt_o
);

  typedef enum logic [PHASE_W-1:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } phase_t;

  localparam logic [OPCODE_W-1:0] OP_HLT = 3'd0;
  localparam logic [OPCODE_W-1:0] OP_SKZ = 3'd1;
  localparam logic [OPCODE_W-1:0] OP_ADD = 3'd2;
  localparam logic [OPCODE_W-1:0] OP_AND = 3'd3;
  localparam logic [OPCODE_W-1:0] OP_XOR = 3'd4;
  localparam logic [OPCODE_W-1:0] OP_LDA = 3'd5;
  localparam logic [OPCODE_W-1:0] OP_STO = 3'd6;
  localparam logic [OPCODE_W-1:0] OP_JMP = 3'd7;

  phase_t phase_q, phase_d;
  logic   halt_q, halt_d;
  logic   hlt_now;
  logic   aluop;
`ifdef CPU_CTRL_STEP_EN
  logic   stalled_q, stalled_d;
`endif

  assign hlt_now = (phase_q == OP_ADDR) && (opcode_i == OP_HLT);
  assign aluop   = (opcode_i == OP_ADD) || (opcode_i == OP_AND) ||
                   (opcode_i == OP_XOR) || (opcode_i == OP_LDA);

  // Halt freezes the phase at OP_ADDR; only rst can leave it.
  always_comb begin
    phase_d = phase_q;
    halt_d  = halt_q;
`ifdef CPU_CTRL_STEP_EN
    stalled_d = stalled_q;
    if (halt_q || hlt_now) begin
      halt_d = 1'b1;
    end else if (stalled_q) begin
      if (step_i) begin
        stalled_d = 1'b0;
        phase_d   = INST_FETCH;
      end
    end else if (phase_q == STORE) begin
      phase_d   = INST_ADDR;
      stalled_d = 1'b1;
    end else begin
      phase_d = phase_t'(phase_q + 1'b1);
    end
`else
    if (halt_q || hlt_now) begin
      halt_d = 1'b1;
    end else begin
      phase_d = phase_t'(phase_q + 1'b1);
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q   <= INST_ADDR;
      halt_q    <= 1'b0;
`ifdef CPU_CTRL_STEP_EN
      stalled_q <= 1'b0;
`endif
    end else begin
      phase_q   <= phase_d;
      halt_q    <= halt_d;
`ifdef CPU_CTRL_STEP_EN
      stalled_q <= stalled_d;
`endif
    end
  end

  always_comb begin
    sel_o    = 1'b0;
    rd_o     = 1'b0;
    ld_ir_o  = 1'b0;
    inc_pc_o = 1'b0;
    ld_pc_o  = 1'b0;
    ld_ac_o  = 1'b0;
    wr_o     = 1'b0;
    data_e_o = 1'b0;
    case (phase_q)
      INST_ADDR:  sel_o = 1'b1;
      INST_FETCH: begin
        sel_o = 1'b1;
        rd_o  = 1'b1;
      end
      INST_LOAD, IDLE: begin
        sel_o   = 1'b1;
        rd_o    = 1'b1;
        ld_ir_o = 1'b1;
      end
      OP_ADDR:    inc_pc_o = !(halt_q || hlt_now);
      OP_FETCH:   rd_o = aluop;
      ALU_OP: begin
        rd_o     = aluop;
        inc_pc_o = (opcode_i == OP_SKZ) && zero_i;
        ld_pc_o  = (opcode_i == OP_JMP);
        data_e_o = (opcode_i == OP_STO);
      end
      STORE: begin
        rd_o     = aluop;
        ld_ac_o  = aluop;
        ld_pc_o  = (opcode_i == OP_JMP);
        data_e_o = (opcode_i == OP_STO);
        wr_o     = (opcode_i == OP_STO);
      end
      default: ;
    endcase
  end

  assign phase_o = phase_q;
  assign halt_o  = halt_q || hlt_now;
`ifdef CPU_CTRL_STEP_EN
  assign stalled_o = stalled_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cpu_controller.sv
`default_nettype none
// Self-checking bench for cpu_controller: scoreboard of per-cycle expected outputs
// produced by an independent phase/halt/stall model.
module tb_cpu_controller;

  logic       clk;
  logic       rst;
  logic [2:0] opcode;
  logic       zero;
  logic       step;
  logic       stalled;
  logic [2:0] phase_o;
  logic       sel_o, rd_o, ld_ir_o, inc_pc_o, ld_pc_o, ld_ac_o, wr_o, data_e_o, halt_o;

  int checks = 0;
  int errors = 0;

  logic [2:0]  m_phase;
  logic        m_halt;
  logic        m_stall;
  logic [12:0] sb_q[$];

  cpu_controller dut (
    .clk      (clk),
    .rst      (rst),
    .opcode_i (opcode),
    .zero_i   (zero),
`ifdef CPU_CTRL_STEP_EN
    .step_i   (step),
    .stalled_o(stalled),
`endif
    .phase_o  (phase_o),
    .sel_o    (sel_o),
    .rd_o     (rd_o),
    .ld_ir_o  (ld_ir_o),
    .inc_pc_o (inc_pc_o),
    .ld_pc_o  (ld_pc_o),
    .ld_ac_o  (ld_ac_o),
    .wr_o     (wr_o),
    .data_e_o (data_e_o),
    .halt_o   (halt_o)
  );

`ifndef CPU_CTRL_STEP_EN
  assign stalled = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {phase, sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt, stalled}
  function automatic logic [12:0] model_exp();
    logic alu, e_sel, e_rd, e_ldir, e_inc, e_ldpc, e_ldac, e_wr, e_de, e_hlt;
    alu    = (opcode >= 3'd2) && (opcode <= 3'd5);
    e_hlt  = m_halt || (m_phase == 3'd4 && opcode == 3'd0);
    e_sel  = (m_phase <= 3'd3);
    e_rd   = (m_phase >= 3'd1 && m_phase <= 3'd3) || (m_phase >= 3'd5 && alu);
    e_ldir = (m_phase == 3'd2) || (m_phase == 3'd3);
    e_inc  = (m_phase == 3'd4 && !e_hlt) || (m_phase == 3'd6 && opcode == 3'd1 && zero);
    e_ldpc = (m_phase >= 3'd6) && (opcode == 3'd7);
    e_ldac = (m_phase == 3'd7) && alu;
    e_wr   = (m_phase == 3'd7) && (opcode == 3'd6);
    e_de   = (m_phase >= 3'd6) && (opcode == 3'd6);
    return {m_phase, e_sel, e_rd, e_ldir, e_inc, e_ldpc, e_ldac, e_wr, e_de, e_hlt, m_stall};
  endfunction

  function automatic logic [12:0] observed();
    return {phase_o, sel_o, rd_o, ld_ir_o, inc_pc_o, ld_pc_o, ld_ac_o, wr_o, data_e_o,
            halt_o, stalled};
  endfunction

  function automatic void model_step();
    if (m_halt) begin
    end else if (m_phase == 3'd4 && opcode == 3'd0) begin
      m_halt = 1'b1;
    end else if (m_stall) begin
      if (step) begin
        m_stall = 1'b0;
        m_phase = 3'd1;
      end
    end else if (m_phase == 3'd7) begin
      m_phase = 3'd0;
`ifdef CPU_CTRL_STEP_EN
      m_stall = 1'b1;
`endif
    end else begin
      m_phase = m_phase + 3'd1;
    end
  endfunction

  // Check the current cycle against the scoreboard, then advance one clock.
  task automatic tick(input string name);
    logic [12:0] exp_v, obs_v;
    sb_q.push_back(model_exp());
    exp_v = sb_q.pop_front();
    obs_v = observed();
    checks++;
    if (obs_v !== exp_v) begin
      errors++;
      $display("FAIL %s phase%0d: got %b expected %b", name, m_phase, obs_v, exp_v);
    end
    checks++;
    if ((rd_o && wr_o) || (ld_pc_o && inc_pc_o)) begin
      errors++;
      $display("FAIL %s exclusive phase%0d: rd=%b wr=%b ld_pc=%b inc_pc=%b expected no overlap",
               name, m_phase, rd_o, wr_o, ld_pc_o, inc_pc_o);
    end
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    m_phase = 3'd0;
    m_halt  = 1'b0;
    m_stall = 1'b0;
    rst = 1'b0;
  endtask

  task automatic run_instr(input logic [2:0] op, input logic z, input string name);
    do_reset();
    opcode = op;
    zero   = z;
    for (int i = 0; i < 8; i++) tick(name);
  endtask

  task automatic test_reset();
    do_reset();
    opcode = 3'd5;
    zero   = 1'b0;
    for (int i = 0; i < 5; i++) tick("reset_pre");
    checks++;
    if (phase_o !== 3'd5) begin
      errors++;
      $display("FAIL reset_pre_phase: got %0d expected 5", phase_o);
    end
    rst = 1'b1;
    #1;
    m_phase = 3'd0;
    m_halt  = 1'b0;
    m_stall = 1'b0;
    checks++;
    if (observed() !== 13'b000_1000000000) begin
      errors++;
      $display("FAIL reset_async: got %b expected %b", observed(), 13'b000_1000000000);
    end
    #1;
    rst = 1'b0;
    tick("reset_post");
  endtask

  task automatic test_lda();
    run_instr(3'd5, 1'b0, "lda");
  endtask

  task automatic test_alu_ops();
    run_instr(3'd2, 1'b1, "add");
    run_instr(3'd3, 1'b0, "and");
    run_instr(3'd4, 1'b0, "xor");
  endtask

  task automatic test_skz();
    run_instr(3'd1, 1'b1, "skz_z1");
    run_instr(3'd1, 1'b0, "skz_z0");
  endtask

  task automatic test_jmp_sto();
    run_instr(3'd7, 1'b0, "jmp");
    run_instr(3'd6, 1'b1, "sto");
  endtask

  task automatic test_hlt();
    do_reset();
    opcode = 3'd0;
    zero   = 1'b0;
    for (int i = 0; i < 25; i++) tick("hlt");
    opcode = 3'd2;
    tick("hlt_opchg");
    checks++;
    if (phase_o !== 3'd4 || halt_o !== 1'b1 || inc_pc_o !== 1'b0 || wr_o !== 1'b0) begin
      errors++;
      $display("FAIL hlt_hold: got phase=%0d halt=%b inc_pc=%b wr=%b expected 4 1 0 0",
               phase_o, halt_o, inc_pc_o, wr_o);
    end
    do_reset();
    tick("hlt_exit");
  endtask

  task automatic test_back_to_back();
    logic [2:0] ops [4];
    ops = '{3'd5, 3'd6, 3'd1, 3'd7};
    do_reset();
    zero = 1'b1;
    step = 1'b1;
    for (int k = 0; k < 4; k++) begin
      opcode = ops[k];
      for (int i = 0; i < 8; i++) tick("b2b");
    end
    step = 1'b0;
  endtask

`ifdef CPU_CTRL_STEP_EN
  task automatic test_step();
    do_reset();
    opcode = 3'd2;
    zero   = 1'b0;
    step   = 1'b0;
    for (int i = 0; i < 18; i++) tick("step_stall");
    step = 1'b1;
    tick("step_pulse");
    step = 1'b0;
    checks++;
    if (phase_o !== 3'd1 || stalled !== 1'b0) begin
      errors++;
      $display("FAIL step_release: got phase=%0d stalled=%b expected 1 0", phase_o, stalled);
    end
    tick("step_run");
    tick("step_run");
    step = 1'b1;
    tick("step_ignored");
    step = 1'b0;
    for (int i = 0; i < 4; i++) tick("step_run");
  endtask
`endif

  initial begin
    rst    = 1'b1;
    opcode = 3'd0;
    zero   = 1'b0;
    step   = 1'b0;
    m_phase = 3'd0;
    m_halt  = 1'b0;
    m_stall = 1'b0;
    #1;
    test_reset();
    test_lda();
    test_alu_ops();
    test_skz();
    test_jmp_sto();
    test_hlt();
    test_back_to_back();
`ifdef CPU_CTRL_STEP_EN
    test_step();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
